// File: rtl/classify_layer_seq.sv
// Time-multiplexed classification layer: one shared MAC walks every output class,
// then reports saturated (optionally ReLU-clamped) scores and the argmax index.
module classify_layer_seq #(
    parameter int INPUT_BITLENGTH  = 12,
    parameter int OUTPUT_BITLENGTH = 8,
    parameter int IN_DIM           = 5,
    parameter int OUT_DIM          = 2,
    parameter int ACC_BITLENGTH    = 28,
    parameter int SHIFT            = 0,
    parameter int IDX_BITLENGTH    = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          relu_en,
    input  logic [IN_DIM*INPUT_BITLENGTH-1:0]             InputHV,
    input  logic [IN_DIM*OUT_DIM*INPUT_BITLENGTH-1:0]     C_WeightI,
    input  logic [OUT_DIM*INPUT_BITLENGTH-1:0]            C_BiasI,
    output logic                                          busy,
    output logic                                          done,
    output logic [OUT_DIM*OUTPUT_BITLENGTH-1:0]           Output,
    output logic [IDX_BITLENGTH-1:0]                      ClassIdx
);

    localparam int IB  = INPUT_BITLENGTH;
    localparam int OB  = OUTPUT_BITLENGTH;
    localparam int AW  = ACC_BITLENGTH;
    localparam int PW  = 2 * INPUT_BITLENGTH;
    localparam int I_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam logic [I_W-1:0]           I_LAST = I_W'(IN_DIM - 1);
    localparam logic [IDX_BITLENGTH-1:0] J_LAST = IDX_BITLENGTH'(OUT_DIM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Clamp an accumulator-width value into the signed output range.
    function automatic logic signed [OB-1:0] saturate(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = {{(AW-OB+1){1'b0}}, {(OB-1){1'b1}}};
        lo = ~hi;
        if (v > hi) begin
            return hi[OB-1:0];
        end else if (v < lo) begin
            return lo[OB-1:0];
        end else begin
            return v[OB-1:0];
        end
    endfunction

    state_t                            state_r;
    state_t                            next_s;
    logic [IN_DIM*IB-1:0]              in_r;
    logic [IN_DIM*OUT_DIM*IB-1:0]      w_r;
    logic [OUT_DIM*IB-1:0]             b_r;
    logic                              relu_r;
    logic [I_W-1:0]                    i_r;
    logic [IDX_BITLENGTH-1:0]          j_r;
    logic signed [AW-1:0]              acc_r;
    logic [OUT_DIM*OB-1:0]             res_r;
    logic signed [OB-1:0]              max_r;
    logic [IDX_BITLENGTH-1:0]          arg_r;
    logic [OUT_DIM*OB-1:0]             output_r;
    logic [IDX_BITLENGTH-1:0]          class_idx_r;
    logic                              busy_r;
    logic                              done_r;

    logic signed [IB-1:0]              in_el_s;
    logic signed [IB-1:0]              w_el_s;
    logic signed [IB-1:0]              b_el_s;
    logic signed [PW-1:0]              prod_s;
    logic signed [AW-1:0]              shift_s;
    logic signed [AW-1:0]              relu_s;
    logic signed [OB-1:0]              sat_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign Output   = output_r;
    assign ClassIdx = class_idx_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: next_s = MAC;
            MAC: begin
                if (i_r == I_LAST) begin
                    next_s = WRITE;
                end else begin
                    next_s = MAC;
                end
            end
            WRITE: begin
                if (j_r == J_LAST) begin
                    next_s = DONE;
                end else begin
                    next_s = LOAD;
                end
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Operand selection, product, shift, ReLU clamp and saturation.
    always_comb begin
        in_el_s = in_r[int'(i_r)*IB +: IB];
        w_el_s  = w_r[(int'(i_r)*OUT_DIM + int'(j_r))*IB +: IB];
        b_el_s  = b_r[int'(j_r)*IB +: IB];
        prod_s  = PW'(in_el_s) * PW'(w_el_s);
        shift_s = acc_r >>> SHIFT;
        if (relu_r && shift_s[AW-1]) begin
            relu_s = '0;
        end else begin
            relu_s = shift_s;
        end
        sat_s = saturate(relu_s);
    end

    // Operand latch, accumulator, result buffer, running argmax and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r        <= '0;
            w_r         <= '0;
            b_r         <= '0;
            relu_r      <= 1'b0;
            i_r         <= '0;
            j_r         <= '0;
            acc_r       <= '0;
            res_r       <= '0;
            max_r       <= '0;
            arg_r       <= '0;
            output_r    <= '0;
            class_idx_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // busy trails the state by one edge so it drops together with done
            busy_r <= (state_r != IDLE);
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        in_r   <= InputHV;
                        w_r    <= C_WeightI;
                        b_r    <= C_BiasI;
                        relu_r <= relu_en;
                        j_r    <= '0;
                    end
                end
                LOAD: begin
                    acc_r <= AW'(b_el_s);
                    i_r   <= '0;
                end
                MAC: begin
                    acc_r <= acc_r + AW'(prod_s);
                    i_r   <= i_r + I_W'(1);
                end
                WRITE: begin
                    res_r[int'(j_r)*OB +: OB] <= sat_s;
                    if ((j_r == '0) || (sat_s > max_r)) begin
                        max_r <= sat_s;
                        arg_r <= j_r;
                    end
                    if (j_r != J_LAST) begin
                        j_r <= j_r + IDX_BITLENGTH'(1);
                    end
                end
                DONE: begin
                    output_r    <= res_r;
                    class_idx_r <= arg_r;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classify_layer_seq.sv
// Self-checking bench for classify_layer_seq: directed cases plus randomized runs
// compared every cycle against a timing/arithmetic model of the layer.
module tb_classify_layer_seq;

    localparam int IB      = 12;
    localparam int OB      = 8;
    localparam int IN_DIM  = 5;
    localparam int OUT_DIM = 2;
    localparam int ACC     = 28;
    localparam int SHIFT   = 0;
    localparam int IDXB    = 1;
    localparam int LAT     = OUT_DIM * (IN_DIM + 2) + 1;

    logic                            clk;
    logic                            rst;
    logic                            start;
    logic                            relu_en;
    logic [IN_DIM*IB-1:0]            InputHV;
    logic [IN_DIM*OUT_DIM*IB-1:0]    C_WeightI;
    logic [OUT_DIM*IB-1:0]           C_BiasI;
    logic                            busy;
    logic                            done;
    logic [OUT_DIM*OB-1:0]           Output;
    logic [IDXB-1:0]                 ClassIdx;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int hv_a [IN_DIM];
    int w_a  [IN_DIM][OUT_DIM];
    int b_a  [OUT_DIM];

    int                    run;
    logic [OUT_DIM*OB-1:0] exp_out;
    logic [IDXB-1:0]       exp_idx;
    logic [OUT_DIM*OB-1:0] held_out;
    logic [IDXB-1:0]       held_idx;

    classify_layer_seq #(
        .INPUT_BITLENGTH (IB),
        .OUTPUT_BITLENGTH(OB),
        .IN_DIM          (IN_DIM),
        .OUT_DIM         (OUT_DIM),
        .ACC_BITLENGTH   (ACC),
        .SHIFT           (SHIFT),
        .IDX_BITLENGTH   (IDXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .relu_en  (relu_en),
        .InputHV  (InputHV),
        .C_WeightI(C_WeightI),
        .C_BiasI  (C_BiasI),
        .busy     (busy),
        .done     (done),
        .Output   (Output),
        .ClassIdx (ClassIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < IN_DIM; i++) begin
            InputHV[i*IB +: IB] = hv_a[i][IB-1:0];
            for (int j = 0; j < OUT_DIM; j++) begin
                C_WeightI[(i*OUT_DIM+j)*IB +: IB] = w_a[i][j][IB-1:0];
            end
        end
        for (int j = 0; j < OUT_DIM; j++) begin
            C_BiasI[j*IB +: IB] = b_a[j][IB-1:0];
        end
    endtask

    task automatic randomize_inputs(input bit wide);
        for (int i = 0; i < IN_DIM; i++) begin
            hv_a[i] = wide ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 40)) - 20;
            for (int j = 0; j < OUT_DIM; j++) begin
                w_a[i][j] = wide ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 40)) - 20;
            end
        end
        for (int j = 0; j < OUT_DIM; j++) begin
            b_a[j] = int'($urandom_range(0, 4095)) - 2048;
        end
        pack_inputs();
    endtask

    // Reference: plain integer dot product, shift, clamp, saturate, first-max index.
    function automatic void model_eval(input logic [IN_DIM*IB-1:0] hv,
                                       input logic [IN_DIM*OUT_DIM*IB-1:0] w,
                                       input logic [OUT_DIM*IB-1:0] b,
                                       input logic relu,
                                       output logic [OUT_DIM*OB-1:0] o,
                                       output logic [IDXB-1:0] idx);
        longint acc, r, best;
        logic signed [IB-1:0] x, y;
        logic [63:0] rv;
        o = '0; idx = '0; best = 0;
        for (int j = 0; j < OUT_DIM; j++) begin
            x = b[j*IB +: IB];
            acc = longint'(x);
            for (int i = 0; i < IN_DIM; i++) begin
                x = hv[i*IB +: IB];
                y = w[(i*OUT_DIM+j)*IB +: IB];
                acc += longint'(x) * longint'(y);
            end
            r = acc >>> SHIFT;
            if (relu && r < 0) r = 0;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            rv = r;
            o[j*OB +: OB] = rv[OB-1:0];
            if (j == 0 || r > best) begin
                best = r;
                idx = IDXB'(j);
            end
        end
    endfunction

    // Model of the handshake timeline and of the held outputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run      = -1;
            held_out = '0;
            held_idx = '0;
            exp_out  = '0;
            exp_idx  = '0;
        end else begin
            if (run == -1 || run == LAT) begin
                if (start) begin
                    run = 0;
                    model_eval(InputHV, C_WeightI, C_BiasI, relu_en, exp_out, exp_idx);
                end else begin
                    run = -1;
                end
            end else begin
                run = run + 1;
                if (run == LAT) begin
                    held_out = exp_out;
                    held_idx = exp_idx;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("done", done, (run == LAT));
            chk("busy", busy, (run >= 1 && run <= LAT));
            chk("Output", Output, held_out);
            chk("ClassIdx", ClassIdx, held_idx);
        end
    end

    // mode 0: plain, 1: random start pulses and input churn, 2: pulses at cycles 3 and 9
    task automatic do_run(input int mode);
        int k, bc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start_edge", busy, 1'b0);
        k = 0; bc = 0;
        while (!done && k < 40) begin
            if (mode == 1) begin
                start = ($urandom_range(0, 2) == 0);
                randomize_inputs($urandom_range(0, 1) == 1);
                relu_en = $urandom_range(0, 1);
            end else if (mode == 2 && (k == 2 || k == 8)) begin
                start = 1'b1;
                for (int i = 0; i < IN_DIM; i++) begin
                    hv_a[i] = 0;
                    for (int j = 0; j < OUT_DIM; j++) w_a[i][j] = 0;
                end
                for (int j = 0; j < OUT_DIM; j++) b_a[j] = 0;
                pack_inputs();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            if (busy) bc++;
        end
        start = 1'b0;
        chk("latency", k, LAT);
        chk("busy_cycles", bc, LAT);
    endtask

    task automatic set_basic();
        for (int i = 0; i < IN_DIM; i++) begin
            hv_a[i] = i + 1;
            w_a[i][0] = 1;
            w_a[i][1] = 2;
        end
        b_a[0] = 3;
        b_a[1] = -5;
        relu_en = 1'b0;
        pack_inputs();
    endtask

    initial begin
        int dc;
        rst = 1'b0;
        start = 1'b0;
        set_basic();
        #2 rst = 1'b1;
        #1;
        chk("reset_Output", Output, '0);
        chk("reset_ClassIdx", ClassIdx, '0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // basic case
        set_basic();
        do_run(0);
        chk("basic_Output", Output, 16'h1912);
        chk("basic_ClassIdx", ClassIdx, 1'b1);

        // saturation
        for (int i = 0; i < IN_DIM; i++) begin
            hv_a[i] = 100; w_a[i][0] = 100; w_a[i][1] = -100;
        end
        b_a[0] = 0; b_a[1] = 0;
        pack_inputs();
        do_run(0);
        chk("sat_Output", Output, 16'h807F);
        chk("sat_ClassIdx", ClassIdx, 1'b0);

        // ReLU and tie, then without ReLU
        for (int i = 0; i < IN_DIM; i++) hv_a[i] = 0;
        b_a[0] = -100; b_a[1] = -7;
        relu_en = 1'b1;
        pack_inputs();
        do_run(0);
        chk("relu_Output", Output, 16'h0000);
        chk("relu_ClassIdx", ClassIdx, 1'b0);
        relu_en = 1'b0;
        do_run(0);
        chk("norelu_Output", Output, 16'hF99C);
        chk("norelu_ClassIdx", ClassIdx, 1'b1);

        // handshake robustness
        set_basic();
        do_run(2);
        chk("hs_Output", Output, 16'h1912);
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("hs_extra_done", dc, 0);
        chk("hs_Output_hold", Output, 16'h1912);

        // reset mid-run
        set_basic();
        do_run(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_Output", Output, '0);
        chk("midrst_ClassIdx", ClassIdx, '0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("midrst_no_done", dc, 0);
        do_run(0);
        chk("after_rst_Output", Output, 16'h1912);
        chk("after_rst_ClassIdx", ClassIdx, 1'b1);

        // randomized runs, checked by the per-cycle compare process
        for (int t = 0; t < 40; t++) begin
            randomize_inputs($urandom_range(0, 1) == 1);
            relu_en = $urandom_range(0, 1);
            do_run((t % 3 == 0) ? 1 : 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
